// File: rtl/sensor_pkg.sv
// Shared constants for the doorway sensor direction decoder: FSM state codes,
// default filter/timeout settings and the timeout counter width helper.
package sensor_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_IN_A     = 3'd1;
  localparam logic [2:0] ST_IN_AB    = 3'd2;
  localparam logic [2:0] ST_IN_B     = 3'd3;
  localparam logic [2:0] ST_OUT_B    = 3'd4;
  localparam logic [2:0] ST_OUT_AB   = 3'd5;
  localparam logic [2:0] ST_OUT_A    = 3'd6;
  localparam logic [2:0] ST_WAIT_CLR = 3'd7;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEF_TIMEOUT_CYCLES  = 24'd5000000;

  // A zero timeout still needs a 1-bit counter so the port-free logic elaborates.
  function automatic int timeout_cnt_width(input logic [23:0] t);
    if (t == 24'd0) begin
      return 1;
    end else begin
      return $clog2({8'd0, t} + 32'd1);
    end
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser for one raw beam sensor, followed by a consecutive-cycle
// debounce filter when SENSOR_DEBOUNCE_EN is defined (pass-through otherwise).
module debounce_filter
  import sensor_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);

  logic [1:0] r_sync;

  // Metastability guard for the asynchronous sensor input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  logic [15:0] r_cnt;
  logic        r_filt;
  logic        w_expire;

  // Counting from zero, the change is accepted on the DEBOUNCE_CYCLES-th differing sample.
  assign w_expire = ({1'b0, r_cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES};

  // Any agreeing cycle restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 16'd0;
      r_filt <= 1'b0;
    end else if (r_sync[1] == r_filt) begin
      r_cnt  <= 16'd0;
    end else if (w_expire) begin
      r_cnt  <= 16'd0;
      r_filt <= r_sync[1];
    end else begin
      r_cnt  <= r_cnt + 16'd1;
    end
  end

  assign o_filt = r_filt;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^DEBOUNCE_CYCLES;
  assign o_filt       = r_sync[1];
`endif

endmodule

// File: rtl/sensor_direction_decoder.sv
// Turns outer (A) / inner (B) beam-break sensors into one-cycle entry (x) / exit (y)
// pulses. Optional input debouncing is enabled with the SENSOR_DEBOUNCE_EN macro.
module sensor_direction_decoder
  import sensor_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic x,
  output logic y,
  output logic busy,
  output logic err
);

  localparam int            TW     = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic          w_a, w_b;
  logic [1:0]    w_ab;
  logic [2:0]    r_state, w_dec_next, w_next;
  logic [TW-1:0] r_cnt;
  logic          w_dec_x, w_dec_y, w_dec_err, w_timeout;
  logic          r_x, r_y, r_err, r_busy;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .i_raw(a_in), .o_filt(w_a)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .i_raw(b_in), .o_filt(w_b)
  );

  assign w_ab = {w_a, w_b};

  // Passage decode on filtered {a,b}; 00 means the doorway is clear.
  always_comb begin
    w_dec_next = r_state;
    w_dec_x    = 1'b0;
    w_dec_y    = 1'b0;
    w_dec_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_ab)
          2'b10:   w_dec_next = ST_IN_A;
          2'b01:   w_dec_next = ST_OUT_B;
          2'b11:   begin w_dec_next = ST_WAIT_CLR; w_dec_err = 1'b1; end
          default: w_dec_next = ST_IDLE;
        endcase
      end
      ST_IN_A: begin
        case (w_ab)
          2'b11:   w_dec_next = ST_IN_AB;
          2'b00:   w_dec_next = ST_IDLE;
          2'b01:   begin w_dec_next = ST_WAIT_CLR; w_dec_err = 1'b1; end
          default: w_dec_next = ST_IN_A;
        endcase
      end
      ST_IN_AB: begin
        case (w_ab)
          2'b01:   w_dec_next = ST_IN_B;
          2'b10:   w_dec_next = ST_IN_A;
          2'b00:   begin w_dec_next = ST_IDLE; w_dec_err = 1'b1; end
          default: w_dec_next = ST_IN_AB;
        endcase
      end
      ST_IN_B: begin
        case (w_ab)
          2'b00:   begin w_dec_next = ST_IDLE; w_dec_x = 1'b1; end
          2'b11:   w_dec_next = ST_IN_AB;
          2'b10:   begin w_dec_next = ST_WAIT_CLR; w_dec_err = 1'b1; end
          default: w_dec_next = ST_IN_B;
        endcase
      end
      ST_OUT_B: begin
        case (w_ab)
          2'b11:   w_dec_next = ST_OUT_AB;
          2'b00:   w_dec_next = ST_IDLE;
          2'b10:   begin w_dec_next = ST_WAIT_CLR; w_dec_err = 1'b1; end
          default: w_dec_next = ST_OUT_B;
        endcase
      end
      ST_OUT_AB: begin
        case (w_ab)
          2'b10:   w_dec_next = ST_OUT_A;
          2'b01:   w_dec_next = ST_OUT_B;
          2'b00:   begin w_dec_next = ST_IDLE; w_dec_err = 1'b1; end
          default: w_dec_next = ST_OUT_AB;
        endcase
      end
      ST_OUT_A: begin
        case (w_ab)
          2'b00:   begin w_dec_next = ST_IDLE; w_dec_y = 1'b1; end
          2'b11:   w_dec_next = ST_OUT_AB;
          2'b01:   begin w_dec_next = ST_WAIT_CLR; w_dec_err = 1'b1; end
          default: w_dec_next = ST_OUT_A;
        endcase
      end
      ST_WAIT_CLR: begin
        case (w_ab)
          2'b00:   w_dec_next = ST_IDLE;
          default: w_dec_next = ST_WAIT_CLR;
        endcase
      end
      default: w_dec_next = ST_IDLE;
    endcase
  end

  // A stalled passage overrides whatever the sensors decode to in the same cycle.
  assign w_timeout = (TIMEOUT_CYCLES != 24'd0) && (r_cnt == TO_MAX) &&
                     (r_state != ST_IDLE) && (r_state != ST_WAIT_CLR);
  assign w_next    = w_timeout ? ST_WAIT_CLR : w_dec_next;

  // State, saturating dwell counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (r_state == ST_IDLE)) begin
        r_cnt <= '0;
      end else if (r_cnt != TO_MAX) begin
        r_cnt <= r_cnt + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      r_x    <= w_dec_x & ~w_timeout;
      r_y    <= w_dec_y & ~w_timeout;
      r_err  <= w_dec_err | w_timeout;
      r_busy <= (w_next != ST_IDLE);
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_sensor_direction_decoder.sv
// Self-checking bench for sensor_direction_decoder: vector table, hand-written corner
// sequences and a randomized run against a doorway-position reference model.
module tb_sensor_direction_decoder;

  localparam logic [15:0] DEB = 16'd4;
  localparam logic [23:0] TO  = 24'd100;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int LAT    = 7;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, a_in, b_in;
  logic x, y, busy, err;

  always #5 clk = ~clk;

  sensor_direction_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .x(x), .y(y), .busy(busy), .err(err)
  );

  int checks = 0, errors = 0;
  int n_x, n_y, n_err, cyc = 0, first_busy, first_err;
  bit seen_busy, excl_bad = 1'b0, prev_pulse = 1'b0;

  typedef struct {
    string       name;
    logic [15:0] seq;
    int          len;
    int          ex, ey, eerr;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_x = 0; n_y = 0; n_err = 0; seen_busy = 1'b0;
    first_busy = -1; first_err = -1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (x) n_x++;
      if (y) n_y++;
      if (err) begin
        n_err++;
        if (first_err < 0) first_err = cyc;
      end
      if (busy) begin
        seen_busy = 1'b1;
        if (first_busy < 0) first_busy = cyc;
      end
      if (x && y) excl_bad = 1'b1;
      if ((x || y) && prev_pulse) excl_bad = 1'b1;
      prev_pulse = x || y;
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    a_in = ab[1];
    b_in = ab[0];
    step(n);
  endtask

  task automatic set_vec(input int i, input string nm, input logic [15:0] s, input int l,
                         input int ex, input int ey, input int ee);
    vecs[i].name = nm; vecs[i].seq = s; vecs[i].len = l;
    vecs[i].ex = ex; vecs[i].ey = ey; vecs[i].eerr = ee;
  endtask

  // Reference model: passage tracked as a direction plus a position 1..3 along the doorway.
  bit m_active, m_exit, m_wait;
  int m_pos;

  function automatic int raw_pos(input logic [1:0] v);
    return (v == 2'b10) ? 1 : (v == 2'b11) ? 2 : 3;
  endfunction

  task automatic model_apply(input logic [1:0] v, output int ex, output int ey, output int ee);
    int p;
    ex = 0; ey = 0; ee = 0;
    if (m_wait) begin
      if (v == 2'b00) m_wait = 1'b0;
    end else if (!m_active) begin
      if (v == 2'b10) begin m_active = 1'b1; m_exit = 1'b0; m_pos = 1; end
      else if (v == 2'b01) begin m_active = 1'b1; m_exit = 1'b1; m_pos = 1; end
      else if (v == 2'b11) begin m_wait = 1'b1; ee = 1; end
    end else if (v == 2'b00) begin
      m_active = 1'b0;
      if (m_pos == 3) begin
        if (m_exit) ey = 1; else ex = 1;
      end else if (m_pos == 2) begin
        ee = 1;
      end
    end else begin
      p = m_exit ? 4 - raw_pos(v) : raw_pos(v);
      if (p - m_pos == 1 || m_pos - p == 1) begin
        m_pos = p;
      end else begin
        m_active = 1'b0; m_wait = 1'b1; ee = 1;
      end
    end
  endtask

  initial begin
    logic [1:0] cur, v;
    int ex, ey, ee, hold;

    set_vec(0, "entry",        16'b10_11_01_00_00_00_00_00, 4, 1, 0, 0);
    set_vec(1, "exit",         16'b01_11_10_00_00_00_00_00, 4, 0, 1, 0);
    set_vec(2, "backout_in",   16'b10_11_10_00_00_00_00_00, 4, 0, 0, 0);
    set_vec(3, "backout_out",  16'b01_11_01_00_00_00_00_00, 4, 0, 0, 0);
    set_vec(4, "jump_a_to_b",  16'b10_01_00_00_00_00_00_00, 3, 0, 0, 1);
    set_vec(5, "both_at_idle", 16'b11_00_00_00_00_00_00_00, 2, 0, 0, 1);
    set_vec(6, "abort_in_ab",  16'b10_11_00_00_00_00_00_00, 3, 0, 0, 1);
    set_vec(7, "entry_wiggle", 16'b10_11_10_11_01_11_01_00, 8, 1, 0, 0);
    set_vec(8, "exit_wiggle",  16'b01_11_10_11_10_00_00_00, 6, 0, 1, 0);
    set_vec(9, "reverse_in_b", 16'b10_11_01_10_00_00_00_00, 5, 0, 0, 1);

    reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
    clr();
    step(3);
    check("reset_outputs", int'({x, y, busy, err}), 0);
    reset = 1'b0;
    step(5);

    for (int i = 0; i < 10; i++) begin
      clr();
      for (int k = 0; k < vecs[i].len; k++) drive(vecs[i].seq[15 - 2*k -: 2], 12);
      check({vecs[i].name, "_x"}, n_x, vecs[i].ex);
      check({vecs[i].name, "_y"}, n_y, vecs[i].ey);
      check({vecs[i].name, "_err"}, n_err, vecs[i].eerr);
      check({vecs[i].name, "_busy_end"}, int'(busy), 0);
    end

    // Latency of the first filtered edge, seen on busy.
    clr();
    a_in = 1'b1; b_in = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      cyc++;
      if (k == LAT - 1) check("latency_busy_early", int'(busy), 0);
      if (k == LAT) check("latency_busy_on", int'(busy), 1);
    end
    drive(2'b10, 8); drive(2'b11, 12); drive(2'b01, 12); drive(2'b00, 12);
    check("latency_entry_x", n_x, 1);

    // Exit: busy throughout, drops with the pulse.
    clr();
    drive(2'b01, 12);
    check("exit_busy_b", int'(busy), 1);
    drive(2'b11, 12); drive(2'b10, 12);
    check("exit_busy_a", int'(busy), 1);
    drive(2'b00, 12);
    check("exit_y", n_y, 1);
    check("exit_busy_end", int'(busy), 0);

    // Two-cycle glitch on A.
    clr();
    drive(2'b10, 2);
    drive(2'b00, 20);
    check("glitch_busy_seen", int'(seen_busy), DEB_ON ? 0 : 1);
    check("glitch_pulses", n_x + n_y + n_err, 0);

    // Stuck on A: timeout abort after TO+1 cycles in IN_A, then WAIT_CLR.
    clr();
    drive(2'b10, 150);
    check("stuck_err", n_err, 1);
    check("stuck_x", n_x, 0);
    check("stuck_timeout_cycles", first_err - first_busy, int'(TO) + 1);
    check("stuck_busy_waitclr", int'(busy), 1);
    drive(2'b00, 12);
    check("stuck_busy_cleared", int'(busy), 0);
    check("stuck_err_total", n_err, 1);

    // Reset while in IN_B.
    clr();
    drive(2'b10, 12); drive(2'b11, 12); drive(2'b01, 12);
    check("rst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("rst_async_outputs", int'({x, y, busy, err}), 0);
    clr();
    a_in = 1'b0; b_in = 1'b0;
    step(2);
    reset = 1'b0;
    step(15);
    check("rst_no_pulse", n_x + n_y + n_err, 0);
    check("rst_busy", int'(busy), 0);

    // Randomized passages against the model.
    m_active = 1'b0; m_exit = 1'b0; m_wait = 1'b0; m_pos = 0;
    cur = 2'b00;
    for (int s = 0; s < 60; s++) begin
      v = cur;
      while (v == cur) v = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(12, 30));
      model_apply(v, ex, ey, ee);
      clr();
      drive(v, hold);
      check("rand_x", n_x, ex);
      check("rand_y", n_y, ey);
      check("rand_err", n_err, ee);
      check("rand_busy", int'(busy), int'(m_active || m_wait));
      cur = v;
    end

    check("x_y_exclusive_spacing", int'(excl_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
